// File: rtl/dual_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_seg_pkg
// Brief    : Segment codes, frame FSM states and pattern decoder shared by
//            the two-digit seven-segment read-back logic.
// Revision : 1.0 - initial release
// ============================================================================
package dual_seg_pkg;

    // Active-low patterns with the decimal point off (bit7 = 1)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HAVE1 = 2'd1,
        HAVE2 = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] bcd;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [7:0] pat, input logic allow_blank);
        seg_dec_t res;
        res.legal = 1'b1;
        res.bcd   = 4'd0;
        case (pat)
            SEG_0:     res.bcd = 4'd0;
            SEG_1:     res.bcd = 4'd1;
            SEG_2:     res.bcd = 4'd2;
            SEG_3:     res.bcd = 4'd3;
            SEG_4:     res.bcd = 4'd4;
            SEG_5:     res.bcd = 4'd5;
            SEG_6:     res.bcd = 4'd6;
            SEG_7:     res.bcd = 4'd7;
            SEG_8:     res.bcd = 4'd8;
            SEG_9:     res.bcd = 4'd9;
            SEG_BLANK: res.legal = allow_blank;
            default:   res.legal = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_digit_filter.sv
`default_nettype none
// ============================================================================
// Module   : seg_digit_filter
// Brief    : Stability filter and decoder for one multiplexed digit. Strobes
//            commit once per selection window when the pattern has held for
//            STABLE_CYCLES samples. Optional macro: DUAL_SEG_READER_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_digit_filter
    import dual_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ALLOW_BLANK   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [7:0] seg_in,
    output logic       commit,
    output logic       legal,
    output logic [3:0] bcd
`ifdef DUAL_SEG_READER_DP_EN
    ,
    output logic       dp
`endif
);

    localparam int               CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(STABLE_CYCLES);

    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_same;
    logic [7:0]       w_pat;
    seg_dec_t         w_dec;

    always_comb begin
        w_same    = (seg_in == r_cand);
        w_cnt_nxt = '0;
        if (sel) begin
            if (!w_same)
                w_cnt_nxt = CNT_W'(1);
            else if (r_cnt == C_FULL)
                w_cnt_nxt = C_FULL;
            else
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // A fresh pattern reaching full count also commits (only possible when STABLE_CYCLES is 1)
        commit = sel && (w_cnt_nxt == C_FULL) && ((r_cnt != C_FULL) || !w_same);
    end

`ifdef DUAL_SEG_READER_DP_EN
    assign w_pat = {1'b1, seg_in[6:0]};
    assign dp    = ~seg_in[7];
`else
    assign w_pat = seg_in;
`endif

    assign w_dec = seg_decode(w_pat, ALLOW_BLANK);
    assign legal = w_dec.legal;
    assign bcd   = w_dec.bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= SEG_BLANK;
            r_cnt  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (sel && !w_same)
                r_cand <= seg_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dual_seg_reader.sv
`default_nettype none
// ============================================================================
// Module   : dual_seg_reader
// Brief    : Reads a multiplexed active-low two-digit display bus back into
//            BCD frames. Optional macro: DUAL_SEG_READER_DP_EN adds dp1/dp2.
// Revision : 1.0 - initial release
// ============================================================================
module dual_seg_reader
    import dual_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [1:0] dig_sel,
    output logic [3:0] data1,
    output logic [3:0] data2,
    output logic       valid,
    output logic       err
`ifdef DUAL_SEG_READER_DP_EN
    ,
    output logic       dp1,
    output logic       dp2
`endif
);

    logic         w_cmt1, w_leg1, w_cmt2, w_leg2;
    logic [3:0]   w_bcd1, w_bcd2;
    logic         w_emit, w_err;
    logic [3:0]   r_pend1, r_pend2;
    frame_state_t r_state, w_state_nxt;

`ifdef DUAL_SEG_READER_DP_EN
    logic w_dp1, w_dp2;
    logic r_pdp1, r_pdp2;
`endif

    seg_digit_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .ALLOW_BLANK   (1'b0)
    ) u_dig1 (
        .clk    (clk),
        .rst    (rst),
        .sel    (dig_sel == 2'b10),
        .seg_in (seg_in),
        .commit (w_cmt1),
        .legal  (w_leg1),
        .bcd    (w_bcd1)
`ifdef DUAL_SEG_READER_DP_EN
        ,
        .dp     (w_dp1)
`endif
    );

    seg_digit_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .ALLOW_BLANK   (1'b1)
    ) u_dig2 (
        .clk    (clk),
        .rst    (rst),
        .sel    (dig_sel == 2'b01),
        .seg_in (seg_in),
        .commit (w_cmt2),
        .legal  (w_leg2),
        .bcd    (w_bcd2)
`ifdef DUAL_SEG_READER_DP_EN
        ,
        .dp     (w_dp2)
`endif
    );

    // Selection is exclusive, so at most one of w_cmt1/w_cmt2 is high per cycle
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        if ((w_cmt1 && !w_leg1) || (w_cmt2 && !w_leg2)) begin
            w_err       = 1'b1;
            w_state_nxt = EMPTY;
        end else if (w_cmt1) begin
            if (r_state == HAVE2) begin
                w_emit      = 1'b1;
                w_state_nxt = EMPTY;
            end else begin
                w_state_nxt = HAVE1;
            end
        end else if (w_cmt2) begin
            if (r_state == HAVE1) begin
                w_emit      = 1'b1;
                w_state_nxt = EMPTY;
            end else begin
                w_state_nxt = HAVE2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend1 <= 4'd0;
            r_pend2 <= 4'd0;
            data1   <= 4'd0;
            data2   <= 4'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= w_emit;
            err   <= w_err;
            if (w_cmt1 && w_leg1)
                r_pend1 <= w_bcd1;
            if (w_cmt2 && w_leg2)
                r_pend2 <= w_bcd2;
            if (w_emit) begin
                data1 <= w_cmt1 ? w_bcd1 : r_pend1;
                data2 <= w_cmt2 ? w_bcd2 : r_pend2;
            end
        end
    end

`ifdef DUAL_SEG_READER_DP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pdp1 <= 1'b0;
            r_pdp2 <= 1'b0;
            dp1    <= 1'b0;
            dp2    <= 1'b0;
        end else begin
            if (w_cmt1 && w_leg1)
                r_pdp1 <= w_dp1;
            if (w_cmt2 && w_leg2)
                r_pdp2 <= w_dp2;
            if (w_emit) begin
                dp1 <= w_cmt1 ? w_dp1 : r_pdp1;
                dp2 <= w_cmt2 ? w_dp2 : r_pdp2;
            end
        end
    end
`endif

endmodule
`default_nettype wire
